// File: rtl/change_dispenser.sv
// change_dispenser
//   Pays out a loaded credit as a sequence of 12/8/4-unit coins, largest
//   first. Each coin is preceded by TICK_DIV cycles of pacing and is then
//   offered to the ejector with a valid/ready handshake. The remaining
//   balance is shown in decimal on two active-low seven-segment digits.
//
// Parameters
//   TICK_DIV    pacing interval in cycles before each coin offer (>= 1)
//   MAX_CREDIT  largest legal credit (multiple of 4, <= 28)
//
// Ports
//   CLOCK_50    system clock, rising edge
//   RESET_N     synchronous active-low reset
//   load        one-cycle payout request, credit sampled with it
//   credit      amount to pay out
//   coin_ready  ejector accepts the offered coin
//   coin_valid  a coin is offered
//   coin_value  value of the offered coin (4, 8, 12; 0 when idle)
//   busy        payout in progress
//   done        one-cycle pulse when the balance reaches 0
//   err         one-cycle pulse on a rejected load
//   HEX1/HEX0   remaining balance, tens/ones digit

module change_dispenser #(
    parameter int TICK_DIV   = 25_000_000,
    parameter int MAX_CREDIT = 28
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       load,
    input  logic [4:0] credit,
    input  logic       coin_ready,
    output logic       coin_valid,
    output logic [3:0] coin_value,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [0:6] HEX1,
    output logic [0:6] HEX0
);

    // Counter only has to reach TICK_DIV-1.
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] PACE_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PACE,
        S_OFFER,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [4:0]       rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic             coin_valid_q;
    logic [3:0]       coin_value_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic             credit_legal_d;
    logic [4:0]       rem_after_d;
    logic [1:0]       tens_d;
    logic [4:0]       ones_d;

    // Largest coin that fits the balance; rem is a nonzero multiple of 4
    // whenever this is used, so 4 is always a valid fallback.
    function automatic logic [3:0] coin_for(input logic [4:0] r);
        if (r >= 5'd12)     coin_for = 4'd12;
        else if (r >= 5'd8) coin_for = 4'd8;
        else                coin_for = 4'd4;
    endfunction

    // Active-low segment patterns, listed in port bit order 0..6.
    function automatic logic [0:6] seg7(input logic [4:0] d);
        case (d)
            5'd0:    seg7 = 7'b0000001;
            5'd1:    seg7 = 7'b1001111;
            5'd2:    seg7 = 7'b0010010;
            5'd3:    seg7 = 7'b0000110;
            5'd4:    seg7 = 7'b1001100;
            5'd5:    seg7 = 7'b0100100;
            5'd6:    seg7 = 7'b0100000;
            5'd7:    seg7 = 7'b0001111;
            5'd8:    seg7 = 7'b0000000;
            5'd9:    seg7 = 7'b0001100;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        credit_legal_d = (credit[1:0] == 2'b00) && (credit <= 5'(MAX_CREDIT));
        rem_after_d    = rem_q - 5'(coin_value_q);
    end

    // Binary to two decimal digits; balance never exceeds 28.
    always_comb begin
        tens_d = 2'd0;
        ones_d = rem_q;
        if (rem_q >= 5'd20) begin
            tens_d = 2'd2;
            ones_d = rem_q - 5'd20;
        end else if (rem_q >= 5'd10) begin
            tens_d = 2'd1;
            ones_d = rem_q - 5'd10;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_q      <= S_IDLE;
            rem_q        <= 5'd0;
            cnt_q        <= '0;
            coin_valid_q <= 1'b0;
            coin_value_q <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (load) begin
                        if (!credit_legal_d) begin
                            err_q <= 1'b1;
                        end else if (credit == 5'd0) begin
                            // Nothing to pay: report completion straight away.
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            rem_q   <= credit;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= S_PACE;
                        end
                    end
                end
                S_PACE: begin
                    if (cnt_q == PACE_LAST) begin
                        // Coin value latched here so it stays stable until accepted.
                        state_q      <= S_OFFER;
                        coin_valid_q <= 1'b1;
                        coin_value_q <= coin_for(rem_q);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_OFFER: begin
                    if (coin_ready) begin
                        rem_q        <= rem_after_d;
                        coin_valid_q <= 1'b0;
                        coin_value_q <= 4'd0;
                        cnt_q        <= '0;
                        if (rem_after_d == 5'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_PACE;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign coin_valid = coin_valid_q;
    assign coin_value = coin_value_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign HEX1       = seg7({3'b000, tens_d});
    assign HEX0       = seg7(ones_d);

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser
//   Scenario tasks drive loads and push the expected coin sequence into a
//   queue; a negedge monitor pops and compares on every handshake and checks
//   the balance display one cycle after each accepted coin.

module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       RESET_N;
    logic       load;
    logic [4:0] credit;
    logic       coin_ready;
    logic       coin_valid;
    logic [3:0] coin_value;
    logic       busy;
    logic       done;
    logic       err;
    logic [0:6] HEX1;
    logic [0:6] HEX0;

    always #5 clk = ~clk;

    change_dispenser #(.TICK_DIV(4), .MAX_CREDIT(28)) dut (
        .CLOCK_50   (clk),
        .RESET_N    (RESET_N),
        .load       (load),
        .credit     (credit),
        .coin_ready (coin_ready),
        .coin_valid (coin_valid),
        .coin_value (coin_value),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .HEX1       (HEX1),
        .HEX0       (HEX0)
    );

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int exp_rem = 0;
    int done_cnt = 0;
    int hs_cnt = 0;
    int mon_e;
    bit hex_pending = 1'b0;

    function automatic logic [0:6] seg7(input int d);
        case (d)
            0: seg7 = 7'b0000001;
            1: seg7 = 7'b1001111;
            2: seg7 = 7'b0010010;
            3: seg7 = 7'b0000110;
            4: seg7 = 7'b1001100;
            5: seg7 = 7'b0100100;
            6: seg7 = 7'b0100000;
            7: seg7 = 7'b0001111;
            8: seg7 = 7'b0000000;
            9: seg7 = 7'b0001100;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Handshake monitor: a coin is transferred at the edge following a
    // negedge that sees valid & ready with reset released.
    always @(negedge clk) begin
        if (RESET_N) begin
            if (hex_pending) begin
                hex_pending = 1'b0;
                checks++;
                if ({HEX1, HEX0} !== {seg7(exp_rem / 10), seg7(exp_rem % 10)}) begin
                    errors++;
                    $display("FAIL hex_after_coin: got %b_%b expected balance %0d", HEX1, HEX0, exp_rem);
                end
            end
            if (done) done_cnt++;
            if (coin_valid && coin_ready) begin
                checks++;
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_coin: got value %0d expected no coin", coin_value);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (coin_value !== 4'(mon_e)) begin
                        errors++;
                        $display("FAIL coin_value: got %0d expected %0d", coin_value, mon_e);
                    end
                    exp_rem = exp_rem - mon_e;
                    hex_pending = 1'b1;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_load(input int c);
        cyc();
        load   = 1'b1;
        credit = 5'(c);
        cyc();
        load   = 1'b0;
    endtask

    // Returns number of negedges until coin_valid is seen (bounded).
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!coin_valid && n < 100);
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; load = 1'b0; credit = 5'd0; coin_ready = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        checks++;
        if ({coin_valid, busy, done, err, coin_value} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b b=%b d=%b e=%b val=%0d expected all 0",
                     coin_valid, busy, done, err, coin_value);
        end
        checks++;
        if ({HEX1, HEX0} !== {seg7(0), seg7(0)}) begin
            errors++;
            $display("FAIL reset_hex: got %b_%b expected 00", HEX1, HEX0);
        end
        cyc();
        RESET_N = 1'b1;
        repeat (2) cyc();
    endtask

    task automatic test_credit20();
        int n;
        int d0;
        coin_ready = 1'b1;
        d0 = done_cnt;
        exp_q.push_back(12); exp_q.push_back(8); exp_rem = 20;
        do_load(20);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || {HEX1, HEX0} !== {seg7(2), seg7(0)}) begin
            errors++;
            $display("FAIL c20_start: got busy=%b hex=%b_%b expected busy=1 hex 20", busy, HEX1, HEX0);
        end
        wait_valid(n);
        n = n + 1; // first negedge after load already consumed above
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL c20_first_latency: got %0d cycles expected 5", n);
        end
        wait_valid(n);
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL c20_second_latency: got %0d cycles expected 5", n);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL c20_done: got done=%b busy=%b expected 1 1", done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || done_cnt - d0 != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL c20_end: got done=%b busy=%b pulses=%0d left=%0d expected 0 0 1 0",
                     done, busy, done_cnt - d0, exp_q.size());
        end
    endtask

    task automatic test_credit28();
        int n;
        int d0;
        coin_ready = 1'b1;
        d0 = done_cnt;
        exp_q.push_back(12); exp_q.push_back(12); exp_q.push_back(4); exp_rem = 28;
        do_load(28);
        for (int i = 0; i < 3; i++) begin
            wait_valid(n);
            checks++;
            if (n != 5) begin
                errors++;
                $display("FAIL c28_latency coin %0d: got %0d cycles expected 5", i, n);
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1 || exp_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL c28_end: got pulses=%0d left=%0d busy=%b expected 1 0 0",
                     done_cnt - d0, exp_q.size(), busy);
        end
    endtask

    task automatic test_ready_low();
        int n;
        coin_ready = 1'b0;
        exp_q.push_back(8); exp_rem = 8;
        do_load(8);
        wait_valid(n);
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL stall_latency: got %0d cycles expected 5", n);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (coin_valid !== 1'b1 || coin_value !== 4'd8) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: got v=%b val=%0d expected 1 8", i, coin_valid, coin_value);
            end
        end
        cyc();
        coin_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || coin_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_release: got done=%b v=%b left=%0d expected 1 0 0", done, coin_valid, exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_rejects();
        int bad[3] = '{10, 30, 3};
        int d0;
        coin_ready = 1'b1;
        foreach (bad[i]) begin
            do_load(bad[i]);
            @(negedge clk);
            checks++;
            if (err !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reject_%0d: got err=%b busy=%b expected 1 0", bad[i], err, busy);
            end
            @(negedge clk);
            checks++;
            if (err !== 1'b0 || busy !== 1'b0 || coin_valid !== 1'b0) begin
                errors++;
                $display("FAIL reject_after_%0d: got err=%b busy=%b v=%b expected 0 0 0", bad[i], err, busy, coin_valid);
            end
        end
        d0 = done_cnt;
        do_load(0);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL zero_credit: got done=%b busy=%b err=%b expected 1 1 0", done, busy, err);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_after: got done=%b busy=%b expected 0 0", done, busy);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL zero_pulses: got %0d expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int h0;
        int d0;
        coin_ready = 1'b1;
        h0 = hs_cnt; d0 = done_cnt;
        exp_q.push_back(12); exp_rem = 12;
        do_load(12);
        cyc(); cyc();
        do_load(12);
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_load: got err=%b busy=%b expected 0 1", err, busy);
        end
        wait_valid(n);
        repeat (12) @(negedge clk);
        checks++;
        if (hs_cnt - h0 != 1 || done_cnt - d0 != 1 || exp_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_load_coins: got coins=%0d pulses=%0d busy=%b expected 1 1 0",
                     hs_cnt - h0, done_cnt - d0, busy);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int d0;
        coin_ready = 1'b0;
        exp_q.push_back(12); exp_q.push_back(8); exp_rem = 20;
        do_load(20);
        wait_valid(n);
        checks++;
        if (coin_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_offer: got v=%b expected 1", coin_valid);
        end
        d0 = done_cnt;
        cyc();
        RESET_N = 1'b0;
        coin_ready = 1'b1;
        exp_q.delete();
        exp_rem = 0;
        cyc();
        RESET_N = 1'b1;
        @(negedge clk);
        checks++;
        if ({coin_valid, busy, done, err, coin_value} !== 8'h00 || {HEX1, HEX0} !== {seg7(0), seg7(0)}) begin
            errors++;
            $display("FAIL midreset_outputs: got v=%b b=%b d=%b e=%b val=%0d hex=%b_%b expected all 0, 00",
                     coin_valid, busy, done, err, coin_value, HEX1, HEX0);
        end
        exp_q.push_back(4); exp_rem = 4;
        do_load(4);
        wait_valid(n);
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL midreset_reload_latency: got %0d expected 5", n);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_reload: got pulses=%0d left=%0d expected 1 0", done_cnt - d0, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_credit20();
        test_credit28();
        test_ready_low();
        test_rejects();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending coins expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global bound so a stuck DUT still ends the run.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000ns");
        $fatal(1, "timeout");
    end

endmodule
